dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 19 +
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0] SZ_BYTE = 4'd1;
    localparam logic [3:0] SZ_HALF = 4'd2;

    // A request is illegal for an unsupported size or a misaligned halfword.
    function automatic logic req_illegal(input logic [3:0] size, input logic addr_lsb);
        return !((size == SZ_BYTE) || (size == SZ_HALF)) ||
               ((size == SZ_HALF) && addr_lsb);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the requester not granted most recently wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot grant; no request means no grant.
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU (port 0) and an aux unit (port 1) onto one data memory.
// One transaction in flight: IDLE accepts, ACCESS drives memory for one
// cycle, RESP holds the response until the owner takes it.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    input  logic [1:0][3:0]        req_size,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_write_enable,
    output logic                   mem_read_enable,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic [3:0]             mem_xfer_size,
    input  logic [DATA_W-1:0]      mem_read_data
);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          size_q, size_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]          grant;
    logic [1:0]          req_ready_c;
    logic [1:0]          rsp_valid_c;
    logic                mem_we_c, mem_re_c;
    logic                sel;

    rr_arbiter2 u_rr (
        .valid_i (req_valid),
        .last_i  (ptr_q),
        .grant_o (grant)
    );

    assign sel = grant[1];

    // Next-state, request latching and per-state output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        req_ready_c = 2'b00;
        rsp_valid_c = 2'b00;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_c = grant & req_valid;
                if (|req_ready_c) begin
                    owner_d = sel;
                    ptr_d   = sel;
                    we_d    = req_we[sel];
                    addr_d  = req_addr[sel];
                    wdata_d = req_wdata[sel];
                    size_d  = req_size[sel];
                    if (req_illegal(req_size[sel], req_addr[sel][0])) begin
                        // Illegal requests skip memory and answer with an error.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_we_c = we_q;
                mem_re_c = !we_q;
                if (we_q)
                    rdata_d = '0;
                else if (size_q == SZ_BYTE)
                    rdata_d = DATA_W'(mem_read_data[7:0]);
                else
                    rdata_d = mem_read_data;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_c[owner_q] = 1'b1;
                if (rsp_ready[owner_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset forces every control/response output low immediately, which also
    // kills a write that is mid-ACCESS when reset arrives.
    assign req_ready        = req_ready_c & {2{reset}};
    assign rsp_valid        = rsp_valid_c & {2{reset}};
    assign mem_write_enable = mem_we_c & reset;
    assign mem_read_enable  = mem_re_c & reset;
    assign rsp_rdata        = rdata_q & {DATA_W{reset}};
    assign rsp_err          = err_q & reset;

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_xfer_size  = size_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed little-endian memory.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_ready, req_we;
    logic [1:0][15:0]  req_addr, req_wdata;
    logic [1:0][3:0]   req_size;
    logic [1:0]        rsp_valid, rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;
    logic [15:0]       mem_address, mem_write_data, mem_read_data;
    logic              mem_write_enable, mem_read_enable;
    logic [3:0]        mem_xfer_size;

    typedef struct {
        int          port;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    int          checks = 0, failures = 0, en_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
        .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
    );

    // Memory: combinational read, write on the clock edge.
    assign mem_read_data = {mem[8'(mem_address[7:0] + 8'd1)], mem[mem_address[7:0]]};

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[7:0]] <= mem_write_data[7:0];
            if (mem_xfer_size == 4'd2)
                mem[8'(mem_address[7:0] + 8'd1)] <= mem_write_data[15:8];
        end
        if (mem_write_enable || mem_read_enable) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result for a request, applied to the reference memory.
    function automatic exp_t predict(input int p, input bit we, input logic [15:0] a,
                                     input logic [15:0] d, input logic [3:0] sz);
        exp_t e;
        logic [7:0] i0, i1;
        i0 = a[7:0];
        i1 = 8'(a[7:0] + 8'd1);
        e.port = p; e.rdata = 16'h0; e.err = 1'b0;
        if (!(sz == 4'd1 || (sz == 4'd2 && !a[0]))) e.err = 1'b1;
        else if (we) begin
            ref_mem[i0] = d[7:0];
            if (sz == 4'd2) ref_mem[i1] = d[15:8];
        end else if (sz == 4'd1) e.rdata = {8'h00, ref_mem[i0]};
        else e.rdata = {ref_mem[i1], ref_mem[i0]};
        return e;
    endfunction

    // Called at a negedge; returns at a negedge with the FSM back in IDLE.
    task automatic run_txn(input int p, input bit we, input logic [15:0] a,
                           input logic [15:0] d, input logic [3:0] sz, input int hold);
        int n;
        exp_t e, got;
        logic [15:0] held;
        req_valid = 2'b00; req_valid[p] = 1'b1;
        req_we[p] = we; req_addr[p] = a; req_wdata[p] = d; req_size[p] = sz;
        rsp_ready = 2'b00; rsp_ready[p] = (hold == 0);
        #1;
        n = 0;
        while (!req_ready[p] && n < 20) begin @(negedge clk); #1; n++; end
        if (!req_ready[p]) begin
            chk("accept_timeout", 32'(req_ready), 32'(1 << p));
            req_valid = 2'b00;
            return;
        end
        e = predict(p, we, a, d, sz);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 2'b00;
        n = 1;
        while (!rsp_valid[p] && n < 20) begin @(negedge clk); n++; end
        chk("rsp_latency", 32'(n), e.err ? 32'd1 : 32'd2);
        chk("rsp_onehot", 32'(rsp_valid), 32'(1 << p));
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'(1 << p));
            chk("hold_rdata", 32'(rsp_rdata), 32'(held));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        got = sb.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(got.err));
        rsp_ready[p] = 1'b1;
        @(negedge clk);
        rsp_ready = 2'b00;
        chk("back_idle_no_rsp", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n, en0, last, g;
        exp_t e, got;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        reset = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_addr = '0;
        req_wdata = '0; req_size = '0; rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_en", 32'({mem_write_enable, mem_read_enable}), 32'd0);
        chk("rst_rdata_err", 32'({rsp_rdata, rsp_err}), 32'd0);
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);

        // Halfword write then read back.
        run_txn(0, 1'b1, 16'h0010, 16'hBEEF, 4'd2, 0);
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 4'd2, 0);

        // Byte write into a halfword, then halfword and byte reads.
        run_txn(1, 1'b1, 16'h0020, 16'h1234, 4'd2, 0);
        run_txn(0, 1'b1, 16'h0021, 16'h00A5, 4'd1, 0);
        run_txn(1, 1'b0, 16'h0020, 16'h0000, 4'd2, 0);
        run_txn(0, 1'b0, 16'h0021, 16'h0000, 4'd1, 0);

        // Illegal requests: misaligned halfword and unsupported size.
        en0 = en_cnt;
        run_txn(1, 1'b0, 16'h0011, 16'h0000, 4'd2, 0);
        run_txn(0, 1'b1, 16'h0030, 16'hFFFF, 4'd4, 0);
        chk("illegal_no_mem_en", 32'(en_cnt - en0), 32'd0);
        chk("illegal_no_write", 32'({mem[8'h30], mem[8'h31]}), 32'd0);

        // Contention after reset: both ports always requesting.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_we = 2'b00; req_size[0] = 4'd2; req_size[1] = 4'd2;
        req_addr[0] = 16'h0010; req_addr[1] = 16'h0020;
        req_valid = 2'b11; rsp_ready = 2'b11;
        last = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
            g = (last == 1) ? 0 : 1;
            chk("rr_grant", 32'(req_ready), 32'(1 << g));
            e = predict(g, 1'b0, req_addr[g], 16'h0, 4'd2);
            sb.push_back(e);
            last = g;
            @(negedge clk);
            n = 1;
            while (!rsp_valid[g] && n < 20) begin @(negedge clk); n++; end
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            got = sb.pop_front();
            chk("rr_rdata", 32'(rsp_rdata), 32'(got.rdata));
            @(negedge clk);
        end
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Backpressure: response held for 5 cycles.
        run_txn(0, 1'b0, 16'h0020, 16'h0000, 4'd2, 5);

        // Reset during ACCESS of a write drops it.
        run_txn(0, 1'b1, 16'h0040, 16'h1111, 4'd2, 0);
        req_valid = 2'b01; req_we[0] = 1'b1; req_addr[0] = 16'h0040;
        req_wdata[0] = 16'h5555; req_size[0] = 4'd2; rsp_ready = 2'b00;
        #1;
        chk("drop_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("drop_in_access", 32'(mem_write_enable), 32'd1);
        reset = 1'b0;
        #1;
        chk("drop_we_gated", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        chk("drop_mem_kept", 32'({mem[8'h41], mem[8'h40]}), 32'h1111);
        chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("drop_idle_no_rsp", 32'(rsp_valid), 32'd0);
        run_txn(1, 1'b0, 16'h0040, 16'h0000, 4'd2, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
